// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Merges ALU and load-unit writebacks onto a single register-file write port.
// Each requester has a one-entry holding buffer. Each cycle one full buffer is
// granted and its payload is loaded into a registered output stage.
// Writes from both requesters to the same register leave in age order.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_alu_valid/o_alu_ready          ALU writeback handshake
//   i_alu_addr/i_alu_val             ALU destination register and value
//   i_lsu_valid/o_lsu_ready          load-unit writeback handshake
//   i_lsu_addr/i_lsu_val             load destination register and value
//   o_wr_en/o_wr_addr/o_wr_val       registered register-file write port
//   i_q_addr/o_q_pending             hazard query: a write to i_q_addr is in flight
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_addr,
    input  logic [WIDTH-1:0]  i_alu_val,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [WIDTH-1:0]  i_lsu_val,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_val,
    input  logic [ADDR_W-1:0] i_q_addr,
    output logic              o_q_pending
);

    // r_live holds the ready outputs low while reset is asserted.
    logic              r_live;
    logic              r_a_vld, r_a_old;
    logic [ADDR_W-1:0] r_a_addr;
    logic [WIDTH-1:0]  r_a_val;
    logic              r_l_vld, r_l_old;
    logic [ADDR_W-1:0] r_l_addr;
    logic [WIDTH-1:0]  r_l_val;
    logic              r_rr;  // 0: prefer L, 1: prefer A
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_val;

    logic w_gnt_a, w_gnt_l, w_fill_a, w_fill_l, w_a_old_d, w_l_old_d;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_l = 1'b0;
        if (r_a_vld && r_l_vld) begin
            if (r_a_addr == r_l_addr) begin
                // Same destination: the older write must go first.
                if (r_a_old) w_gnt_a = 1'b1;
                else         w_gnt_l = 1'b1;
            end else if (r_rr) begin
                w_gnt_a = 1'b1;
            end else begin
                w_gnt_l = 1'b1;
            end
        end else begin
            w_gnt_a = r_a_vld;
            w_gnt_l = r_l_vld;
        end
    end

    assign o_alu_ready = r_live && (!r_a_vld || w_gnt_a);
    assign o_lsu_ready = r_live && (!r_l_vld || w_gnt_l);

    // Writes to x0 complete the handshake but never occupy a buffer.
    assign w_fill_a = i_alu_valid && o_alu_ready && (i_alu_addr != '0);
    assign w_fill_l = i_lsu_valid && o_lsu_ready && (i_lsu_addr != '0);

    // Age tracking: a buffer filled next to a full, non-departing buffer is the
    // younger of the two; a simultaneous fill makes L the older one.
    always_comb begin
        w_a_old_d = w_gnt_a ? 1'b0 : r_a_old;
        w_l_old_d = w_gnt_l ? 1'b0 : r_l_old;
        if (w_fill_a && w_fill_l) begin
            w_a_old_d = 1'b0;
            w_l_old_d = 1'b1;
        end else if (w_fill_a) begin
            w_a_old_d = 1'b0;
            if (r_l_vld && !w_gnt_l) w_l_old_d = 1'b1;
        end else if (w_fill_l) begin
            w_l_old_d = 1'b0;
            if (r_a_vld && !w_gnt_a) w_a_old_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live    <= 1'b0;
            r_a_vld   <= 1'b0;
            r_a_old   <= 1'b0;
            r_a_addr  <= '0;
            r_a_val   <= '0;
            r_l_vld   <= 1'b0;
            r_l_old   <= 1'b0;
            r_l_addr  <= '0;
            r_l_val   <= '0;
            r_rr      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_val  <= '0;
        end else begin
            r_live  <= 1'b1;
            r_a_old <= w_a_old_d;
            r_l_old <= w_l_old_d;

            if (w_fill_a) begin
                r_a_vld  <= 1'b1;
                r_a_addr <= i_alu_addr;
                r_a_val  <= i_alu_val;
            end else if (w_gnt_a) begin
                r_a_vld <= 1'b0;
            end

            if (w_fill_l) begin
                r_l_vld  <= 1'b1;
                r_l_addr <= i_lsu_addr;
                r_l_val  <= i_lsu_val;
            end else if (w_gnt_l) begin
                r_l_vld <= 1'b0;
            end

            // After a contested grant the pointer favours the loser.
            if (r_a_vld && r_l_vld) r_rr <= w_gnt_l;

            r_wr_en <= w_gnt_a || w_gnt_l;
            if (w_gnt_a) begin
                r_wr_addr <= r_a_addr;
                r_wr_val  <= r_a_val;
            end else if (w_gnt_l) begin
                r_wr_addr <= r_l_addr;
                r_wr_val  <= r_l_val;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_val  = r_wr_val;

    assign o_q_pending = (i_q_addr != '0) &&
                         ((r_a_vld && (r_a_addr == i_q_addr)) ||
                          (r_l_vld && (r_l_addr == i_q_addr)) ||
                          (r_wr_en && (r_wr_addr == i_q_addr)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a write-ordering model (age sequence numbers,
// round-robin preference) checked every cycle, plus directed scenarios with
// literal expected write sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_addr = '0, lsu_addr = '0, q_addr = '0;
    logic [31:0] alu_val = '0, lsu_val = '0;
    logic        alu_ready, lsu_ready, wr_en, q_pending;
    logic [4:0]  wr_addr;
    logic [31:0] wr_val;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WIDTH(32), .ADDR_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready),
        .i_alu_addr(alu_addr), .i_alu_val(alu_val),
        .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
        .i_lsu_addr(lsu_addr), .i_lsu_val(lsu_val),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_val(wr_val),
        .i_q_addr(q_addr), .o_q_pending(q_pending)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] val;
    } wr_t;
    wr_t         log_q[$];
    wr_t         sa[$];
    wr_t         sl[$];
    logic [31:0] rf[32];

    // Model: each pending write carries a global fill sequence number (its age).
    bit          m_live, m_rr, m_a_vld, m_l_vld, m_wr_en;
    logic [4:0]  m_a_addr, m_l_addr, m_wr_addr;
    logic [31:0] m_a_val, m_l_val, m_wr_val;
    int          m_a_seq, m_l_seq, m_seq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_live = 0; m_rr = 0; m_a_vld = 0; m_l_vld = 0; m_wr_en = 0;
        m_a_addr = '0; m_l_addr = '0; m_wr_addr = '0;
        m_a_val = '0; m_l_val = '0; m_wr_val = '0;
    endtask

    function automatic void model_grant(output bit ga, output bit gl);
        ga = 0;
        gl = 0;
        if (m_a_vld && m_l_vld) begin
            if (m_a_addr == m_l_addr) begin
                if (m_a_seq < m_l_seq) ga = 1;
                else                   gl = 1;
            end else if (m_rr) ga = 1;
            else               gl = 1;
        end else if (m_a_vld) ga = 1;
        else if (m_l_vld)     gl = 1;
    endfunction

    task automatic model_step();
        bit ga, gl, acc_a, acc_l;
        if (!rst_n) begin
            model_clear();
            return;
        end
        model_grant(ga, gl);
        acc_a = alu_valid && m_live && (!m_a_vld || ga);
        acc_l = lsu_valid && m_live && (!m_l_vld || gl);
        if (m_a_vld && m_l_vld) m_rr = ga ? 1'b0 : 1'b1;
        m_wr_en = ga || gl;
        if (ga) begin m_wr_addr = m_a_addr; m_wr_val = m_a_val; m_a_vld = 0; end
        if (gl) begin m_wr_addr = m_l_addr; m_wr_val = m_l_val; m_l_vld = 0; end
        if (acc_l && lsu_addr != 0) begin
            m_l_vld = 1; m_l_addr = lsu_addr; m_l_val = lsu_val; m_l_seq = m_seq++;
        end
        if (acc_a && alu_addr != 0) begin
            m_a_vld = 1; m_a_addr = alu_addr; m_a_val = alu_val; m_a_seq = m_seq++;
        end
        m_live = 1;
    endtask

    task automatic compare();
        bit ga, gl, exp_q;
        model_grant(ga, gl);
        exp_q = (q_addr != 0) && ((m_a_vld && m_a_addr == q_addr) ||
                                  (m_l_vld && m_l_addr == q_addr) ||
                                  (m_wr_en && m_wr_addr == q_addr));
        check("alu_ready", 32'(alu_ready), 32'(m_live && (!m_a_vld || ga)));
        check("lsu_ready", 32'(lsu_ready), 32'(m_live && (!m_l_vld || gl)));
        check("wr_en", 32'(wr_en), 32'(m_wr_en));
        check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        check("wr_val", wr_val, m_wr_val);
        check("q_pending", 32'(q_pending), 32'(exp_q));
        if (wr_en) begin
            log_q.push_back('{addr: wr_addr, val: wr_val});
            rf[wr_addr] = wr_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        alu_valid = 0;
        lsu_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Feeds sa/sl through the handshakes, holding each payload until accepted.
    task automatic run_streams();
        int  ia = 0, il = 0, cyc = 0;
        bit  acc_a, acc_l;
        while ((ia < sa.size() || il < sl.size()) && cyc < 100) begin
            alu_valid = ia < sa.size();
            lsu_valid = il < sl.size();
            if (alu_valid) begin alu_addr = sa[ia].addr; alu_val = sa[ia].val; end
            if (lsu_valid) begin lsu_addr = sl[il].addr; lsu_val = sl[il].val; end
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_a) ia++;
            if (acc_l) il++;
            cyc++;
        end
        check("alu_stream_done", 32'(ia), 32'(sa.size()));
        check("lsu_stream_done", 32'(il), 32'(sl.size()));
        alu_valid = 0;
        lsu_valid = 0;
    endtask

    task automatic expect_log(input int idx, input logic [4:0] a, input logic [31:0] v);
        if (idx < log_q.size()) begin
            check($sformatf("log%0d_addr", idx), 32'(log_q[idx].addr), 32'(a));
            check($sformatf("log%0d_val", idx), log_q[idx].val, v);
        end else begin
            check($sformatf("log%0d_present", idx), 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n9;
        model_clear();
        m_seq = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset state while held low.
        #1;
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_val", wr_val, 32'd0);
        check("rst_q_pending", 32'(q_pending), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
        check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        check("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        check("post_rst_wr_en", 32'(wr_en), 32'd0);

        // ALU only: x5 <= 0x1234, write visible after the second edge, single pulse.
        log_q.delete();
        q_addr = 5'd5;
        alu_valid = 1; alu_addr = 5'd5; alu_val = 32'h1234;
        tick();
        check("alu_only_edge1_wr_en", 32'(wr_en), 32'd0);
        check("alu_only_edge1_pending", 32'(q_pending), 32'd1);
        alu_valid = 0;
        tick();
        check("alu_only_edge2_wr_en", 32'(wr_en), 32'd1);
        check("alu_only_edge2_wr_addr", 32'(wr_addr), 32'd5);
        check("alu_only_edge2_wr_val", wr_val, 32'h1234);
        tick();
        check("alu_only_pulse_end", 32'(wr_en), 32'd0);
        check("alu_only_hold_val", wr_val, 32'h1234);
        idle(2);
        check("alu_only_count", 32'(log_q.size()), 32'd1);

        // Both at once, x3 (ALU) / x4 (LSU): L first, then A.
        log_q.delete();
        alu_valid = 1; alu_addr = 5'd3; alu_val = 32'h33;
        lsu_valid = 1; lsu_addr = 5'd4; lsu_val = 32'h44;
        tick();
        idle(4);
        check("both_diff_count", 32'(log_q.size()), 32'd2);
        expect_log(0, 5'd4, 32'h44);
        expect_log(1, 5'd3, 32'h33);

        // rr now prefers A: x11 (ALU) beats x12 (LSU).
        log_q.delete();
        alu_valid = 1; alu_addr = 5'd11; alu_val = 32'hB1;
        lsu_valid = 1; lsu_addr = 5'd12; lsu_val = 32'hC1;
        tick();
        idle(4);
        expect_log(0, 5'd11, 32'hB1);
        expect_log(1, 5'd12, 32'hC1);

        // Same register from both at once: LSU is older.
        log_q.delete();
        q_addr = 5'd7;
        alu_valid = 1; alu_addr = 5'd7; alu_val = 32'hBB;
        lsu_valid = 1; lsu_addr = 5'd7; lsu_val = 32'hAA;
        tick();
        idle(4);
        expect_log(0, 5'd7, 32'hAA);
        expect_log(1, 5'd7, 32'hBB);
        check("same_addr_final_x7", rf[7], 32'hBB);

        // Back-to-back ALU writes x1..x8.
        log_q.delete();
        for (int i = 1; i <= 8; i++) sa.push_back('{addr: 5'(i), val: 32'(i * 32'h11)});
        run_streams();
        sa.delete();
        idle(3);
        check("b2b_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) expect_log(i, 5'(i + 1), 32'((i + 1) * 32'h11));

        // Write to x0: handshake completes, nothing written.
        log_q.delete();
        q_addr = 5'd0;
        alu_valid = 1; alu_addr = 5'd0; alu_val = 32'hDEAD;
        tick();
        check("x0_pending", 32'(q_pending), 32'd0);
        idle(3);
        check("x0_no_write", 32'(log_q.size()), 32'd0);

        // Mixed contention with backpressure; the model checks every cycle.
        log_q.delete();
        q_addr = 5'd7;
        sa.push_back('{addr: 5'd2, val: 32'h21});
        sa.push_back('{addr: 5'd7, val: 32'h71});
        sa.push_back('{addr: 5'd7, val: 32'h72});
        sa.push_back('{addr: 5'd5, val: 32'h51});
        sl.push_back('{addr: 5'd7, val: 32'h7A});
        sl.push_back('{addr: 5'd2, val: 32'h2A});
        sl.push_back('{addr: 5'd0, val: 32'h00});
        sl.push_back('{addr: 5'd9, val: 32'h9A});
        run_streams();
        sa.delete();
        sl.delete();
        idle(4);
        check("mixed_count", 32'(log_q.size()), 32'd7);

        // Reset mid-operation with L holding x9 and a write in the output stage.
        log_q.delete();
        q_addr = 5'd9;
        alu_valid = 1; alu_addr = 5'd10; alu_val = 32'h10;
        tick();
        alu_valid = 0;
        lsu_valid = 1; lsu_addr = 5'd9; lsu_val = 32'h99;
        tick();
        lsu_valid = 0;
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        check("pre_rst_pending9", 32'(q_pending), 32'd1);
        rst_n = 0;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_pending9", 32'(q_pending), 32'd0);
        model_clear();
        log_q.delete();
        tick();
        tick();
        rst_n = 1;
        idle(5);
        n9 = 0;
        foreach (log_q[i]) if (log_q[i].addr == 5'd9) n9++;
        check("no_x9_after_rst", 32'(n9), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
